selwait: RTL

- Programmable wait-state generator downstream of the I/O chip-select unit.
- Consumes `select1`..`select4` and `bootstrap` during CPU memory cycles and stretches each cycle by a per-select wait count through the registered `ready` output to the CPU.
- Wait counts are held in two I/O-mapped registers written and read over the CPU data bus.

---
 rtl/selwait.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/selwait.sv
// ---------------------------------------------------------------------------
// selwait -- programmable wait-state generator
//
// Sits downstream of the I/O chip-select unit. When a CPU memory cycle
// starts (rising edge of memrd|memwr), the wait count of the
// highest-priority active select is loaded. The registered ready output is
// then held low for exactly that many clocks.
//
// The four 4-bit wait counts are held in two I/O-mapped registers:
//   addr[7:4]==BASE, addr[3:1]==0, addr[0]==0 : WR0 = {wait2, wait1}
//   addr[7:4]==BASE, addr[3:1]==0, addr[0]==1 : WR1 = {wait4, wait3}
//
// Ports:
//   clock      in   CPU clock, rising edge
//   reset      in   synchronous, active-low reset
//   addr[15:0] in   CPU address (only [7:0] are decoded)
//   data[7:0]  io   CPU data bus; driven only during a register read
//   readio     in   I/O read strobe
//   writeio    in   I/O write strobe
//   memrd      in   memory read strobe
//   memwr      in   memory write strobe
//   select1..4 in   chip selects, select1 has the highest priority
//   bootstrap  in   bootstrap mode; forces BOOTWAIT for select1/select2
//   extwait    in   (SELWAIT_EXTWAIT_EN only) stretches COUNT while high
//   ready      out  registered CPU ready, 0 inserts a wait state
//   busy       out  registered, 1 while the FSM is in COUNT
//   fsmstate   out  debug view of the FSM state (0 IDLE, 1 COUNT, 2 DONE)
//
// Optional feature macro: SELWAIT_EXTWAIT_EN adds the extwait input.
//
// Handshake: a memory cycle is the interval during which memrd|memwr is
// high. The CPU may only finish its access in a clock where ready is 1. If
// the strobe drops while waits are still pending, the cycle is abandoned and
// the FSM returns to IDLE at that edge. Every new cycle needs the strobe to
// be low for at least one rising edge first.
// ---------------------------------------------------------------------------
module selwait #(
  parameter logic [3:0] BASE     = 4'h1,
  parameter logic [3:0] DEFWAIT  = 4'hF,
  parameter logic [3:0] BOOTWAIT = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  inout  wire  [7:0]  data,
  input  logic        readio,
  input  logic        writeio,
  input  logic        memrd,
  input  logic        memwr,
  input  logic        select1,
  input  logic        select2,
  input  logic        select3,
  input  logic        select4,
  input  logic        bootstrap,
`ifdef SELWAIT_EXTWAIT_EN
  input  logic        extwait,
`endif
  output logic        ready,
  output logic        busy,
  output logic [1:0]  fsmstate
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] wait1;
  logic [3:0] wait2;
  logic [3:0] wait3;
  logic [3:0] wait4;
  logic [3:0] cnt;
  logic       prevstb;

  logic       acc;
  logic       stb;
  logic       start;
  logic       hold;
  logic [3:0] nwait;
  logic [7:0] rdval;
  logic       unused_addr;

  // Only the low address byte takes part in the register decode.
  assign unused_addr = ^addr[15:8];

  // ------------------------------------------------------------------------
  // Register decode and read-back
  // ------------------------------------------------------------------------
  assign acc   = (addr[7:4] == BASE) && (addr[3:1] == 3'b000);
  assign rdval = addr[0] ? {wait4, wait3} : {wait2, wait1};

  // With readio and writeio both high, the old register value is driven
  // because the write only lands at the next clock edge.
  assign data = (readio && acc) ? rdval : 8'bz;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wait1 <= DEFWAIT;
      wait2 <= DEFWAIT;
      wait3 <= DEFWAIT;
      wait4 <= DEFWAIT;
    end else if (writeio && acc) begin
      if (addr[0]) begin
        wait4 <= data[7:4];
        wait3 <= data[3:0];
      end else begin
        wait2 <= data[7:4];
        wait1 <= data[3:0];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Cycle start detect and wait-count selection
  // ------------------------------------------------------------------------
  assign stb   = memrd | memwr;
  assign start = stb & ~prevstb;

`ifdef SELWAIT_EXTWAIT_EN
  assign hold = extwait;
`else
  assign hold = 1'b0;
`endif

  // Bootstrap overrides only the two highest-priority selects, and only when
  // one of them wins the priority decision.
  always_comb begin
    nwait = 4'd0;
    if (select1) begin
      nwait = bootstrap ? BOOTWAIT : wait1;
    end else if (select2) begin
      nwait = bootstrap ? BOOTWAIT : wait2;
    end else if (select3) begin
      nwait = wait3;
    end else if (select4) begin
      nwait = wait4;
    end
  end

  // ------------------------------------------------------------------------
  // FSM
  // cnt is loaded with N-1. ready is low from the start edge up to the edge
  // where cnt is seen at 0, which gives exactly N low clocks.
  // ------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      prevstb <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      prevstb <= stb;
      case (state)
        IDLE: begin
          if (start) begin
            if (nwait != 4'd0) begin
              state <= COUNT;
              cnt   <= nwait - 4'd1;
              ready <= 1'b0;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              ready <= 1'b1;
            end
          end
        end
        COUNT: begin
          if (!stb) begin
            // The CPU abandoned the cycle; release it right away.
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else if (hold) begin
            cnt <= cnt;
          end else if (cnt == 4'd0) begin
            state <= DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          if (!stb) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fsmstate = state;

endmodule
